// File: rtl/pause_dim.sv
// Frame-aligned pause controller with a timed screen dimmer.
// Pause enters and leaves only on a vblank rising edge.
module pause_dim #(
    parameter int          RW         = 4,
    parameter logic [31:0] DIM_CYCLES = 32'h7270E00
) (
    input  logic            clk_sys,
    input  logic            reset,
    input  logic            user_btn,
    input  logic            osd_pause,
    input  logic            vblank,
    input  logic [RW-1:0]   r_in,
    input  logic [RW-1:0]   g_in,
    input  logic [RW-1:0]   b_in,
    output logic            pause,
    output logic            dimmed,
    output logic [3*RW-1:0] rgb_out
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        PEND_IN  = 2'd1,
        PAUSED   = 2'd2,
        PEND_OUT = 2'd3
    } state_t;

    state_t      state;
    state_t      state_n;
    logic        btn_d;
    logic        vb_d;
    logic        user_latch;
    logic        btn_rise;
    logic        vb_rise;
    logic        req;
    logic        pause_n;
    logic        timer_clr;
    logic        timer_sat;
    logic        dim_now;
    logic [31:0] timer;

    assign btn_rise = user_btn & ~btn_d;
    assign vb_rise  = vblank & ~vb_d;
    assign req      = user_latch | osd_pause;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            btn_d      <= 1'b0;
            vb_d       <= 1'b0;
            user_latch <= 1'b0;
        end else begin
            btn_d <= user_btn;
            vb_d  <= vblank;
            if (btn_rise) begin
                user_latch <= ~user_latch;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            RUN: begin
                if (req & vb_rise) begin
                    state_n = PAUSED;
                end else if (req) begin
                    state_n = PEND_IN;
                end
            end
            PEND_IN: begin
                if (~req) begin
                    state_n = RUN;
                end else if (vb_rise) begin
                    state_n = PAUSED;
                end
            end
            PAUSED: begin
                if (~req) begin
                    state_n = PEND_OUT;
                end
            end
            PEND_OUT: begin
                if (req) begin
                    state_n = PAUSED;
                end else if (vb_rise) begin
                    state_n = RUN;
                end
            end
            default: state_n = RUN;
        endcase
    end

    assign pause   = (state == PAUSED) | (state == PEND_OUT);
    assign pause_n = (state_n == PAUSED) | (state_n == PEND_OUT);

    // Clearing on the way out as well keeps the timer at zero from the
    // first RUN cycle, and clearing while not paused gives t=0 on entry.
    assign timer_clr = ~pause | ~pause_n;
    assign timer_sat = (timer == DIM_CYCLES);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            timer <= 32'd0;
        end else if (timer_clr) begin
            timer <= 32'd0;
        end else if (!timer_sat) begin
            timer <= timer + 32'd1;
        end
    end

    assign dim_now = pause & timer_sat;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            rgb_out <= '0;
            dimmed  <= 1'b0;
        end else begin
            dimmed <= dim_now;
            if (dim_now) begin
                rgb_out <= {r_in >> 1, g_in >> 1, b_in >> 1};
            end else begin
                rgb_out <= {r_in, g_in, b_in};
            end
        end
    end

endmodule

// File: tb/tb_pause_dim.sv
// Scoreboard bench for pause_dim against a cycle-level behavioural model.
// Stimulus pushes expected outputs; a monitor pops and compares each cycle.
module tb_pause_dim;

    localparam int RW  = 4;
    localparam int DIM = 8;

    typedef struct packed {
        logic            p;
        logic            d;
        logic [3*RW-1:0] rgb;
    } exp_t;

    logic            clk_sys = 1'b0;
    logic            reset = 1'b1;
    logic            user_btn = 1'b0;
    logic            osd_pause = 1'b0;
    logic            vblank = 1'b0;
    logic [RW-1:0]   r_in = '0;
    logic [RW-1:0]   g_in = '0;
    logic [RW-1:0]   b_in = '0;
    logic            pause;
    logic            dimmed;
    logic [3*RW-1:0] rgb_out;

    int n_cmp = 0;
    int n_bad = 0;
    exp_t sb[$];

    // model state: what the pause controller should be doing this cycle
    bit m_latch, m_btn_prev, m_vb_prev, m_pause, m_prev_req;
    int m_cnt;

    pause_dim #(.RW(RW), .DIM_CYCLES(32'(DIM))) dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .user_btn (user_btn),
        .osd_pause(osd_pause),
        .vblank   (vblank),
        .r_in     (r_in),
        .g_in     (g_in),
        .b_in     (b_in),
        .pause    (pause),
        .dimmed   (dimmed),
        .rgb_out  (rgb_out)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic step(input bit rst, input bit btn, input bit osd,
                        input bit vb, input logic [RW-1:0] r,
                        input logic [RW-1:0] g, input logic [RW-1:0] b);
        bit   req, vbr, dim, np;
        exp_t e;
        @(negedge clk_sys);
        reset     = rst;
        user_btn  = btn;
        osd_pause = osd;
        vblank    = vb;
        r_in      = r;
        g_in      = g;
        b_in      = b;
        req = m_latch | osd;
        vbr = vb & ~m_vb_prev;
        dim = m_pause && (m_cnt >= DIM);
        // pause follows req at each vblank edge, except that a drop of
        // req seen only in that same cycle is not yet enough to resume
        np = vbr ? (req | (m_pause & m_prev_req)) : m_pause;
        if (rst) begin
            e = '0;
            m_latch = 0; m_btn_prev = 0; m_vb_prev = 0;
            m_pause = 0; m_prev_req = 0; m_cnt = 0;
        end else begin
            e.p   = np;
            e.d   = dim;
            e.rgb = dim ? {r / 4'd2, g / 4'd2, b / 4'd2} : {r, g, b};
            if (btn && !m_btn_prev) m_latch = !m_latch;
            m_btn_prev = btn;
            m_vb_prev  = vb;
            m_cnt      = np ? (m_pause ? ((m_cnt + 1 > DIM) ? DIM : m_cnt + 1) : 0) : 0;
            m_pause    = np;
            m_prev_req = req;
        end
        sb.push_back(e);
    endtask

    task automatic idle(input int n, input bit btn, input bit osd, input bit vb);
        for (int i = 0; i < n; i++) step(0, btn, osd, vb, 4'hF, 4'h9, 4'h1);
    endtask

    always @(posedge clk_sys) begin
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_cmp++;
            if (pause !== e.p) begin
                n_bad++;
                $display("FAIL pause t=%0t got %b want %b", $time, pause, e.p);
            end
            n_cmp++;
            if (dimmed !== e.d) begin
                n_bad++;
                $display("FAIL dimmed t=%0t got %b want %b", $time, dimmed, e.d);
            end
            n_cmp++;
            if (rgb_out !== e.rgb) begin
                n_bad++;
                $display("FAIL rgb_out t=%0t got %h want %h", $time, rgb_out, e.rgb);
            end
        end
    end

    initial begin
        bit btn, osd, vb;
        int ph;
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        // entry: button with no vblank, then vblank edge
        idle(3, 0, 0, 0);
        idle(2, 1, 0, 0);
        idle(5, 0, 0, 0);
        idle(4, 0, 0, 1);
        // dimming and saturation across many frames
        for (int f = 0; f < 25; f++) begin
            idle(30, 0, 0, 0);
            idle(10, 0, 0, 1);
        end
        // exit with re-request from osd before the next vblank edge
        idle(2, 1, 0, 0);
        idle(3, 0, 0, 0);
        idle(3, 0, 1, 0);
        idle(3, 0, 1, 1);
        idle(3, 0, 1, 0);
        idle(3, 0, 0, 0);
        idle(4, 0, 0, 1);
        idle(4, 0, 0, 0);
        // cancel before entry: two presses with no vblank edge
        idle(1, 1, 0, 0);
        idle(1, 0, 0, 0);
        idle(1, 1, 0, 0);
        idle(3, 0, 0, 0);
        idle(3, 0, 0, 1);
        idle(3, 0, 0, 0);
        // same-cycle osd and vblank edge from RUN
        idle(1, 0, 1, 1);
        idle(20, 0, 1, 1);
        idle(3, 0, 0, 0);
        idle(3, 0, 0, 1);
        idle(3, 0, 0, 0);
        // reset mid dimmed pause, then a vblank edge with no press
        idle(2, 1, 0, 0);
        idle(2, 0, 0, 0);
        idle(15, 0, 0, 1);
        step(1, 0, 0, 1, 4'hA, 4'h5, 4'h3);
        idle(3, 0, 0, 0);
        idle(3, 0, 0, 1);
        idle(3, 0, 0, 0);
        // randomized frames, button presses, osd and occasional reset
        btn = 0; osd = 0; vb = 0; ph = 0;
        for (int i = 0; i < 6000; i++) begin
            ph = (ph + 1) % ($urandom_range(20, 60));
            vb = (ph < 6);
            if ($urandom_range(0, 99) < 3) btn = !btn;
            if ($urandom_range(0, 299) == 0) osd = !osd;
            step($urandom_range(0, 1999) == 0, btn, osd, vb,
                 RW'($urandom), RW'($urandom), RW'($urandom));
        end
        @(posedge clk_sys);
        #2;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain got %0d left want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pause_dim.md
# pause_dim

Frame-aligned pause controller and screen dimmer sitting between the arcade core's RGB output and `arcade_video`. It turns a user pause button (toggle) and an OSD pause request into a `pause` signal for the core. Pause entry and exit happen only at the start of vertical blank, so a frame is never torn. After a programmable time in pause, every colour channel is halved to protect the display.

## Interface
Parameters:
- `RW`, 4: bits per colour channel.
- `DIM_CYCLES`, 32'h7270E00: paused clock cycles before dimming (about 10 s at 12 MHz). 0 = dim on the first paused cycle.

Ports:
- `clk_sys`  in  1  system clock; everything is in this domain.
- `reset`  in  1  synchronous, active-high reset.
- `user_btn`  in  1  pause button level; each rising edge toggles the user pause latch.
- `osd_pause`  in  1  level; forces a pause request while high.
- `vblank`  in  1  core vertical blank level.
- `r_in`, `g_in`, `b_in`  in  RW each  core colour channels.
- `pause`  out  1  pause to the core.
- `dimmed`  out  1  high while `rgb_out` is carrying halved colour.
- `rgb_out`  out  3*RW  {r,g,b}, registered.

## Operation
- Button edge detection:
  - `btn_d` is `user_btn` delayed by one cycle.
  - `btn_rise = user_btn & ~btn_d` toggles `user_latch`.
- Pause request: `req = user_latch | osd_pause`.
- Vblank edge detection:
  - `vb_d` is `vblank` delayed by one cycle.
  - `vb_rise = vblank & ~vb_d`.
- State machine, 2-bit:
  - RUN:
    - `req & vb_rise` -> PAUSED.
    - `req & ~vb_rise` -> PEND_IN.
  - PEND_IN:
    - `~req` -> RUN (pause never asserted).
    - else `vb_rise` -> PAUSED.
  - PAUSED: `~req` -> PEND_OUT.
  - PEND_OUT:
    - `req` -> PAUSED.
    - else `vb_rise` -> RUN.
- `pause` = state is PAUSED or PEND_OUT (decoded from the state register).
- Dim timer, 32 bits:
  - Cleared in RUN and PEND_IN.
  - In PAUSED and PEND_OUT it increments each cycle, saturating at `DIM_CYCLES`; it never wraps.
  - Going PEND_OUT -> PAUSED keeps the count.
- `dim_now = pause & (timer == DIM_CYCLES)`.
- Output register, every cycle:
  - `rgb_out <= dim_now ? {r_in>>1, g_in>>1, b_in>>1} : {r_in, g_in, b_in}`, logical shift per channel with MSB = 0.
  - `dimmed <= dim_now`.
- Simultaneous events:
  - A `btn_rise` that clears `user_latch` while `osd_pause` is high leaves `req` high.
  - `req` and `vb_rise` in the same RUN cycle go straight to PAUSED.
- Reset, at any time and including mid-pause or mid-pend:
  - State RUN; `user_latch`, `btn_d`, `vb_d` and timer cleared.
  - `pause`=0, `dimmed`=0, `rgb_out`=0 on the cycle after reset is sampled.

## Timing
- A `btn_rise` sampled at edge k sets `user_latch` at k+1, so `req` is visible in cycle k+1.
- `vb_rise` in cycle m with an entry-eligible state -> `pause`=1 from cycle m+1.
- Exit is symmetric: `vb_rise` in cycle m while in PEND_OUT with `~req` -> `pause`=0 from cycle m+1; the timer is cleared in the same cycle.
- With the first PAUSED cycle as t (timer=0):
  - timer == `DIM_CYCLES` at cycle t+`DIM_CYCLES`;
  - `dimmed`/`rgb_out` dimmed from cycle t+`DIM_CYCLES`+1.
- Colour path latency: exactly 1 cycle, no bubbles.
- Leaving pause: `dimmed` drops 1 cycle after `pause` drops.
- `vblank` held high does not retrigger; only a 0->1 transition counts.

## Test plan
- Entry: reset, `DIM_CYCLES`=8.
  - Pulse `user_btn` with `vblank`=0 -> `pause` stays 0.
  - Raise `vblank` at cycle m -> `pause`=1 at m+1.
  - `rgb_out` = input delayed 1 cycle.
- Dimming: `DIM_CYCLES`=8, inputs r=0xF, g=0x9, b=0x1.
  - `dimmed`=1 and `rgb_out`={0x7,0x4,0x0} exactly 9 cycles after `pause` rises.
  - Holding pause for 1000 more cycles keeps the output unchanged (saturation).
- Cancel before entry: `btn_rise` then a second `btn_rise` before any `vb_rise` -> `pause` never asserts and the timer stays 0.
- Exit with re-request: in PAUSED, toggle the button off, then `osd_pause`=1 before the next `vb_rise`.
  - `pause` stays 1; the timer is not cleared.
  - Drop `osd_pause`, then `vb_rise` -> `pause`=0 one cycle later.
  - `dimmed`=0 one cycle after that.
- Same-cycle: `osd_pause` rises in the same cycle as `vb_rise` from RUN -> `pause`=1 next cycle.
- Reset mid-pause: dimmed pause, assert `reset` for 1 cycle -> next cycle `pause`=0, `dimmed`=0, `rgb_out`=0.
  - A later `vb_rise` with no button press -> `pause` stays 0.
